lutnn_stream_classifier: RTL
============================

# lutnn_stream_classifier

Sequential front/back end for the combinational LUTNN network (`top`). It accepts a binarised image as a stream of fixed-width beats and assembles it into the flat `NET_INPUTS`-bit vector the network consumes. It waits a configurable network latency, then reduces the network outputs by per-class group popcount and argmax. The winning class index and score are returned over a valid/ready handshake. The network itself stays outside this block and is connected through `net_i`/`net_o`.

## Interface
- `NET_INPUTS`, 400: network input width; must be a multiple of `BEAT_W`.
- `BEAT_W`, 20: bits per input beat (one 20-pixel image row).
- `CLASSES`, 10: number of output classes.
- `GROUP`, 1: network output bits per class. The network output width is `CLASSES*GROUP`.
- `NET_LAT`, 0: pipeline latency of the attached network in cycles (0 = combinational).

Ports:
- `clk`, in, 1: single clock; all state is on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `s_valid`, in, 1: input beat valid.
- `s_ready`, out, 1: block accepts a beat.
- `s_data`, in, `BEAT_W`: image beat; MSB is the leftmost pixel.
- `s_last`, in, 1: marks the final beat of an image.
- `net_i`, out, `NET_INPUTS`: registered image driven to the network.
- `net_o`, in, `CLASSES*GROUP`: network output. Class c occupies bits `[c*GROUP +: GROUP]`.
- `m_valid`, out, 1: result valid.
- `m_ready`, in, 1: result consumer ready.
- `m_class`, out, `$clog2(CLASSES)`: winning class index.
- `m_score`, out, `$clog2(GROUP+1)`: popcount of the winning group.
- `frame_err`, out, 1: one-cycle pulse on a framing error.
- `busy`, out, 1: high in every state except LOAD.

## Operation
- States: LOAD, EVAL, SCORE, OUT.
- **LOAD** (`s_ready`=1)
  - Each handshake shifts `s_data` into the image register. The first beat of a frame lands in `net_i[NET_INPUTS-1 -: BEAT_W]`; the last beat lands in the LSBs.
  - A beat counter counts 0..`BEATS`-1, where `BEATS`=`NET_INPUTS/BEAT_W`.
- **Framing**
  - A correct frame has `s_last`=1 exactly on beat `BEATS`-1. That beat moves the FSM to EVAL.
  - `s_last`=1 on an earlier beat: that beat is discarded, `frame_err` pulses, the counter resets to 0, and the FSM stays in LOAD.
  - `s_last`=0 on beat `BEATS`-1: the beat is stored, `frame_err` pulses, the counter resets, and the FSM stays in LOAD with the image discarded.
  - A partially loaded image is never evaluated.
- **EVAL** (`s_ready`=0)
  - `net_i` is held stable for `NET_LAT`+1 cycles.
  - On the last EVAL cycle, `net_o` is captured into an internal register.
- **SCORE**: runs `CLASSES` cycles, c = 0..`CLASSES`-1.
  - Each cycle computes the popcount of group c.
  - Class 0 initialises `best_class` and `best_score`. Later classes replace the best only if their score is strictly greater, so ties resolve to the lowest index.
  - All-zero groups give class 0 with score 0.
- **OUT**
  - `m_valid`=1, with `m_class` and `m_score` stable until `m_valid && m_ready`.
  - On that handshake the FSM returns to LOAD and the beat counter is 0.
  - `s_ready`=0 in OUT; no input overlaps an unconsumed result.
- **Width rules**
  - Popcount is zero-extended to the `m_score` width.
  - The class counter wraps only via the state transition and never exceeds `CLASSES`-1.

## Timing
- **Reset values**: state=LOAD, `s_ready`=1, `net_i`=0, `m_valid`=0, `m_class`=0, `m_score`=0, `frame_err`=0, `busy`=0, counters=0.
- **Reset mid-operation** (any state): the result is abandoned, there is no `m_valid` pulse, and the block returns to LOAD immediately.
- **Latency**: the last-beat handshake is in cycle T. Then:
  - EVAL spans T+1 .. T+1+`NET_LAT`.
  - SCORE spans the next `CLASSES` cycles.
  - `m_valid` rises at T+2+`NET_LAT`+`CLASSES` (T+12 with defaults).
- **Throughput**: one image per `BEATS`+`NET_LAT`+`CLASSES`+2 cycles at best (32 with defaults).
- `s_ready` drops in the cycle after the last-beat handshake.
- `s_ready` rises in the cycle after the `m_valid`/`m_ready` handshake.
- `frame_err` is registered and asserted for one cycle, in the cycle after the offending beat.
- `net_i` changes only on accepted beats.

## Test plan
- **Nominal, defaults, combinational stub net**
  - Stub: `net_o` = one-hot of a digit decoded from `net_i`.
  - Stream the "seven" image as 20 beats of 20 bits with `s_last` on beat 19, `m_ready`=1.
  - Required: `m_class`=7, `m_score`=1, `m_valid` exactly 12 cycles after the last beat, and `net_i` equal to the 400-bit image.
- **Tie and zero cases**
  - `net_o`=10'b1000000001: `m_class`=0.
  - `net_o`=10'b1100000000: `m_class`=8.
  - `net_o`=0: `m_class`=0, `m_score`=0.
- **GROUP=3, NET_LAT=2**
  - Group scores {1,3,0,3,2,...}: `m_class`=1, `m_score`=3.
  - `m_valid` at T+14.
- **Backpressure**
  - `m_ready`=0 for 7 cycles: `m_valid` and the outputs stay stable, and `s_ready` stays 0.
  - Toggle `s_valid` randomly during LOAD: the image is still assembled correctly.
- **Framing errors**
  - `s_last` on beat 5: `frame_err` pulses once, no result, and the next clean frame classifies correctly.
  - Missing `s_last` on beat 19: same behaviour.
- **Reset mid-SCORE**: assert `rst_n`=0 in the third SCORE cycle. All outputs return to their reset values, no `m_valid` appears, and the next frame gives a correct result.

Source files
------------

// File: rtl/lutnn_stream_classifier.sv
// Stream-in front end and popcount/argmax back end for an external LUTNN network.
// Beats are assembled into net_i, net_o is sampled after NET_LAT cycles, then classes are scored one per cycle.
module lutnn_stream_classifier #(
    parameter int NET_INPUTS = 400,
    parameter int BEAT_W     = 20,
    parameter int CLASSES    = 10,
    parameter int GROUP      = 1,
    parameter int NET_LAT    = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [BEAT_W-1:0]            s_data,
    input  logic                         s_last,
    output logic [NET_INPUTS-1:0]        net_i,
    input  logic [CLASSES*GROUP-1:0]     net_o,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [$clog2(CLASSES)-1:0]   m_class,
    output logic [$clog2(GROUP+1)-1:0]   m_score,
    output logic                         frame_err,
    output logic                         busy
);
    localparam int BEATS   = NET_INPUTS / BEAT_W;
    localparam int BC_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LAT_W   = (NET_LAT > 0) ? $clog2(NET_LAT + 1) : 1;
    localparam int CLS_W   = $clog2(CLASSES);
    localparam int SCORE_W = $clog2(GROUP + 1);
    localparam logic [BC_W-1:0]  LAST_BEAT = BC_W'(BEATS - 1);
    localparam logic [LAT_W-1:0] LAST_LAT  = LAT_W'(NET_LAT);
    localparam logic [CLS_W-1:0] LAST_CLS  = CLS_W'(CLASSES - 1);

    typedef enum logic [1:0] {LOAD, EVAL, SCORE, OUT} state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [BC_W-1:0]           r_beat_cnt;
    logic [LAT_W-1:0]          r_lat_cnt;
    logic [CLS_W-1:0]          r_cls_cnt;
    logic [NET_INPUTS-1:0]     r_img;
    logic [CLASSES*GROUP-1:0]  r_net_cap;
    logic [CLS_W-1:0]          r_best_class;
    logic [SCORE_W-1:0]        r_best_score;
    logic                      r_frame_err;

    logic                      w_beat_hs;
    logic                      w_beat_last;
    logic                      w_good_last;
    logic                      w_early_last;
    logic                      w_missing_last;
    logic [NET_INPUTS-1:0]     w_img_shift;
    logic [GROUP-1:0]          w_group;
    logic [SCORE_W-1:0]        w_pc;

    function automatic logic [SCORE_W-1:0] popcount(input logic [GROUP-1:0] g);
        logic [SCORE_W-1:0] n;
        n = '0;
        for (int i = 0; i < GROUP; i++) n = n + SCORE_W'(g[i]);
        return n;
    endfunction

    assign s_ready   = (r_state == LOAD);
    assign busy      = (r_state != LOAD);
    assign m_valid   = (r_state == OUT);
    assign m_class   = r_best_class;
    assign m_score   = r_best_score;
    assign net_i     = r_img;
    assign frame_err = r_frame_err;

    assign w_beat_hs      = s_valid && s_ready;
    assign w_beat_last    = (r_beat_cnt == LAST_BEAT);
    assign w_good_last    = w_beat_hs && s_last && w_beat_last;
    assign w_early_last   = w_beat_hs && s_last && !w_beat_last;
    assign w_missing_last = w_beat_hs && !s_last && w_beat_last;

    // First beat of a frame ends up in the MSBs after BEATS shifts.
    generate
        if (BEATS > 1) begin : g_shift
            assign w_img_shift = {r_img[NET_INPUTS-BEAT_W-1:0], s_data};
        end else begin : g_single
            assign w_img_shift = s_data;
        end
    endgenerate

    assign w_group = r_net_cap[int'(r_cls_cnt)*GROUP +: GROUP];
    assign w_pc    = popcount(w_group);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= LOAD;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            LOAD:    if (w_good_last) w_state_nxt = EVAL;
            EVAL:    if (r_lat_cnt == LAST_LAT) w_state_nxt = SCORE;
            SCORE:   if (r_cls_cnt == LAST_CLS) w_state_nxt = OUT;
            OUT:     if (m_ready) w_state_nxt = LOAD;
            default: w_state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat_cnt   <= '0;
            r_lat_cnt    <= '0;
            r_cls_cnt    <= '0;
            r_img        <= '0;
            r_net_cap    <= '0;
            r_best_class <= '0;
            r_best_score <= '0;
            r_frame_err  <= 1'b0;
        end else begin
            r_frame_err <= w_early_last || w_missing_last;
            // A premature s_last beat is dropped; any framing decision restarts the count.
            if (w_beat_hs) begin
                if (!w_early_last) r_img <= w_img_shift;
                r_beat_cnt <= (s_last || w_beat_last) ? '0 : r_beat_cnt + 1'b1;
            end
            if (r_state == EVAL) begin
                if (r_lat_cnt == LAST_LAT) begin
                    r_lat_cnt <= '0;
                    r_net_cap <= net_o;
                end else begin
                    r_lat_cnt <= r_lat_cnt + 1'b1;
                end
            end
            // Strictly-greater replacement keeps the lowest index on ties.
            if (r_state == SCORE) begin
                if (r_cls_cnt == '0 || w_pc > r_best_score) begin
                    r_best_class <= r_cls_cnt;
                    r_best_score <= w_pc;
                end
                r_cls_cnt <= (r_cls_cnt == LAST_CLS) ? '0 : r_cls_cnt + 1'b1;
            end
        end
    end
endmodule
